// File: rtl/spi_frame_pkg.sv
// Shared constants, frame layout and helpers for the SPI frame engine.
package spi_frame_pkg;

  localparam int unsigned NUM_REGS   = 10;
  localparam int unsigned FRAME_BITS = 16;

  localparam logic [3:0] CMD_NOP  = 4'h0;
  localparam logic [3:0] CMD_WR   = 4'h1;
  localparam logic [3:0] CMD_RD   = 4'h2;
  localparam logic [3:0] CMD_STAT = 4'h3;

  localparam logic [7:0] RESP_ERR = 8'hFF;

  typedef struct packed {
    logic [3:0] cmd;
    logic [3:0] addr;
    logic [7:0] val;
  } frame_t;

  // Increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_decode.sv
// Combinational frame decoder: accept/reject decision and response word.
module spi_cmd_decode
  import spi_frame_pkg::*;
(
  input  frame_t                  frame,
  input  logic [8*NUM_REGS-1:0]   rd_regs,
  input  logic [7:0]              frame_count,
  input  logic [7:0]              err_count,
  output logic                    accept_wr_c,
  output logic                    reject_c,
  output logic [FRAME_BITS-1:0]   response_c
);

  logic addr_ok_c;

  assign addr_ok_c = 32'(frame.addr) < NUM_REGS;

  always_comb begin
    accept_wr_c = 1'b0;
    reject_c    = 1'b0;
    response_c  = {RESP_ERR, sat_inc8(err_count)};
    case (frame.cmd)
      CMD_NOP:  response_c = {8'h00, frame_count + 8'd1};
      CMD_WR: begin
        if (addr_ok_c) begin
          accept_wr_c = 1'b1;
          response_c  = {frame.cmd, frame.addr, frame.val};
        end else begin
          reject_c = 1'b1;
        end
      end
      CMD_RD: begin
        if (addr_ok_c) begin
          response_c = {frame.cmd, frame.addr, rd_regs[{frame.addr, 3'b000} +: 8]};
        end else begin
          reject_c = 1'b1;
        end
      end
      CMD_STAT: response_c = {frame_count + 8'd1, err_count};
      default:  reject_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/spi_frame_engine.sv
// SPI-domain front end: deserialises 16-bit frames, publishes writes via
// a stable bus + toggle, and returns each frame's response during the next.
module spi_frame_engine
  import spi_frame_pkg::*;
(
  input  logic                   spi_rx_clk_c,
  input  logic                   rst_low_i,
  input  logic                   spi_mosi_i,
  output logic                   spi_miso_o,
  input  logic [8*NUM_REGS-1:0]  rd_regs_i,
  output logic [FRAME_BITS-1:0]  wr_frame_o,
  output logic                   wr_toggle_o,
  output logic [7:0]             frame_count_o,
  output logic [7:0]             err_count_o
);

  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-2:0] rx_shift;
  logic [FRAME_BITS-1:0] tx_shift;
  logic                  frame_end_c;
  frame_t                frame_c;
  logic                  accept_wr_c;
  logic                  reject_c;
  logic [FRAME_BITS-1:0] response_c;

  assign frame_end_c = (bit_cnt == 4'hF);
  assign frame_c     = {rx_shift, spi_mosi_i};
  assign spi_miso_o  = tx_shift[FRAME_BITS-1];

  spi_cmd_decode u_decode (
    .frame       (frame_c),
    .rd_regs     (rd_regs_i),
    .frame_count (frame_count_o),
    .err_count   (err_count_o),
    .accept_wr_c (accept_wr_c),
    .reject_c    (reject_c),
    .response_c  (response_c)
  );

  // Frame sync is purely bit-count based; only reset can realign it.
  always_ff @(posedge spi_rx_clk_c or negedge rst_low_i) begin
    if (!rst_low_i) begin
      bit_cnt       <= 4'd0;
      rx_shift      <= '0;
      tx_shift      <= 16'hFFFF;
      wr_frame_o    <= '0;
      wr_toggle_o   <= 1'b0;
      frame_count_o <= 8'd0;
      err_count_o   <= 8'd0;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
      if (frame_end_c) begin
        tx_shift      <= response_c;
        frame_count_o <= frame_count_o + 8'd1;
        if (accept_wr_c) begin
          wr_frame_o  <= frame_c;
          wr_toggle_o <= ~wr_toggle_o;
        end
        if (reject_c) begin
          err_count_o <= sat_inc8(err_count_o);
        end
      end else begin
        rx_shift <= {rx_shift[FRAME_BITS-3:0], spi_mosi_i};
        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_engine.sv
// Directed self-checking bench for spi_frame_engine with a 2-FF block_clk consumer.
`timescale 1ns/1ps
module tb_spi_frame_engine;

  logic        sclk = 1'b1;
  logic        rst_low = 1'b1;
  logic        mosi = 1'b1;
  logic        miso;
  logic [79:0] rd_regs = '0;
  logic [15:0] wr_frame;
  logic        wr_toggle;
  logic [7:0]  frame_count;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  spi_frame_engine dut (
    .spi_rx_clk_c  (sclk),
    .rst_low_i     (rst_low),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .rd_regs_i     (rd_regs),
    .wr_frame_o    (wr_frame),
    .wr_toggle_o   (wr_toggle),
    .frame_count_o (frame_count),
    .err_count_o   (err_count)
  );

  // block_clk consumer at 4x the SPI clock
  logic        blk_clk = 1'b0;
  logic        s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  logic        cap_en = 1'b0;
  logic [15:0] cap[$];

  initial forever #1 blk_clk = ~blk_clk;

  always @(posedge blk_clk) begin
    s1 <= wr_toggle;
    s2 <= s1;
    s3 <= s2;
    if (cap_en && (s2 !== s3)) cap.push_back(wr_frame);
  end

  // wr_frame stability watcher, in SPI clock edges
  logic        mon_en = 1'b0;
  logic        mon_seen = 1'b0;
  logic [15:0] mon_last = '0;
  int          mon_gap = 0;
  int          stab_viol = 0;

  always @(posedge sclk) begin
    if (mon_en) begin
      #1;
      if (wr_frame !== mon_last) begin
        if (mon_seen && mon_gap < 16) stab_viol++;
        mon_last = wr_frame;
        mon_seen = 1'b1;
        mon_gap  = 1;
      end else begin
        mon_gap++;
      end
    end
  end

  task automatic do_reset();
    rst_low = 1'b0;
    #3;
    rst_low = 1'b1;
    #3;
  endtask

  // Master: drive MOSI while SCLK low, sample MISO just before the rising edge.
  task automatic send_bits(input logic [15:0] d, input int n, output logic [15:0] r);
    r = 16'hFFFF;
    for (int i = 15; i > 15 - n; i--) begin
      sclk = 1'b0;
      mosi = d[i];
      #4;
      r[i] = miso;
      sclk = 1'b1;
      #4;
    end
  endtask

  task automatic send_frame(input logic [15:0] d, output logic [15:0] r);
    send_bits(d, 16, r);
  endtask

  task automatic test_reset();
    do_reset();
    if (wr_toggle !== 1'b0) begin $display("FAIL reset_toggle got %b want 0", wr_toggle); n_fail++; end
    n_checks++;
    if (wr_frame !== 16'h0000) begin $display("FAIL reset_frame got %h want 0000", wr_frame); n_fail++; end
    n_checks++;
    if (frame_count !== 8'h00) begin $display("FAIL reset_fc got %h want 00", frame_count); n_fail++; end
    n_checks++;
    if (err_count !== 8'h00) begin $display("FAIL reset_ec got %h want 00", err_count); n_fail++; end
    n_checks++;
    if (miso !== 1'b1) begin $display("FAIL reset_miso got %b want 1", miso); n_fail++; end
    n_checks++;
  endtask

  task automatic test_write();
    logic [15:0] r;
    do_reset();
    send_frame(16'h1305, r);
    if (r !== 16'hFFFF) begin $display("FAIL wr_first_miso got %h want FFFF", r); n_fail++; end
    n_checks++;
    if (wr_toggle !== 1'b1) begin $display("FAIL wr_toggle got %b want 1", wr_toggle); n_fail++; end
    n_checks++;
    if (wr_frame !== 16'h1305) begin $display("FAIL wr_frame got %h want 1305", wr_frame); n_fail++; end
    n_checks++;
    send_frame(16'h0000, r);
    if (r !== 16'h1305) begin $display("FAIL wr_echo got %h want 1305", r); n_fail++; end
    n_checks++;
    if (wr_toggle !== 1'b1) begin $display("FAIL wr_nop_toggle got %b want 1", wr_toggle); n_fail++; end
    n_checks++;
    if (frame_count !== 8'd2) begin $display("FAIL wr_fc got %h want 02", frame_count); n_fail++; end
    n_checks++;
  endtask

  task automatic test_read();
    logic [15:0] r;
    do_reset();
    for (int n = 0; n < 10; n++) rd_regs[8*n +: 8] = 8'(8'h10 + n);
    rd_regs[8*4 +: 8] = 8'h7C;
    send_frame(16'h2400, r);
    send_frame(16'h0000, r);
    if (r !== 16'h247C) begin $display("FAIL rd_reg4 got %h want 247C", r); n_fail++; end
    n_checks++;
    if (wr_toggle !== 1'b0) begin $display("FAIL rd_toggle got %b want 0", wr_toggle); n_fail++; end
    n_checks++;
    send_frame(16'h2900, r);
    send_frame(16'h0000, r);
    if (r !== 16'h2919) begin $display("FAIL rd_reg9 got %h want 2919", r); n_fail++; end
    n_checks++;
    if (err_count !== 8'd0) begin $display("FAIL rd_ec got %h want 00", err_count); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reject();
    logic [15:0] r;
    do_reset();
    send_frame(16'h1A11, r);
    send_frame(16'h5000, r);
    if (r !== 16'hFF01) begin $display("FAIL rej_resp got %h want FF01", r); n_fail++; end
    n_checks++;
    send_frame(16'h3000, r);
    if (r !== 16'hFF02) begin $display("FAIL rej_resp2 got %h want FF02", r); n_fail++; end
    n_checks++;
    send_frame(16'h0000, r);
    if (r !== 16'h0302) begin $display("FAIL stat_resp got %h want 0302", r); n_fail++; end
    n_checks++;
    if (err_count !== 8'd2) begin $display("FAIL rej_ec got %h want 02", err_count); n_fail++; end
    n_checks++;
    if (frame_count !== 8'd4) begin $display("FAIL rej_fc got %h want 04", frame_count); n_fail++; end
    n_checks++;
    if (wr_toggle !== 1'b0 || wr_frame !== 16'h0000) begin
      $display("FAIL rej_wr got %b/%h want 0/0000", wr_toggle, wr_frame); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_wrap();
    logic [15:0] r;
    do_reset();
    for (int i = 0; i < 255; i++) send_frame(16'h0000, r);
    if (frame_count !== 8'hFF) begin $display("FAIL wrap_fc255 got %h want FF", frame_count); n_fail++; end
    n_checks++;
    send_frame(16'h0000, r);
    if (r !== 16'h00FF) begin $display("FAIL wrap_nop_resp got %h want 00FF", r); n_fail++; end
    n_checks++;
    if (frame_count !== 8'h00) begin $display("FAIL wrap_fc got %h want 00", frame_count); n_fail++; end
    n_checks++;
    for (int i = 0; i < 299; i++) send_frame(16'hF000, r);
    send_frame(16'hF000, r);
    if (r !== 16'hFFFF) begin $display("FAIL sat_resp got %h want FFFF", r); n_fail++; end
    n_checks++;
    if (err_count !== 8'hFF) begin $display("FAIL sat_ec got %h want FF", err_count); n_fail++; end
    n_checks++;
    if (frame_count !== 8'h2C) begin $display("FAIL sat_fc got %h want 2C", frame_count); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] r;
    do_reset();
    send_frame(16'h1305, r);
    send_bits(16'h1207, 9, r);
    if (miso !== 1'b0) begin $display("FAIL mid_miso_pre got %b want 0", miso); n_fail++; end
    n_checks++;
    do_reset();
    if (miso !== 1'b1) begin $display("FAIL mid_miso_rst got %b want 1", miso); n_fail++; end
    n_checks++;
    if (wr_toggle !== 1'b0 || frame_count !== 8'd0) begin
      $display("FAIL mid_rst_state got %b/%h want 0/00", wr_toggle, frame_count); n_fail++;
    end
    n_checks++;
    send_frame(16'h1207, r);
    if (r !== 16'hFFFF) begin $display("FAIL mid_first_miso got %h want FFFF", r); n_fail++; end
    n_checks++;
    if (wr_toggle !== 1'b1) begin $display("FAIL mid_toggle got %b want 1", wr_toggle); n_fail++; end
    n_checks++;
    if (wr_frame !== 16'h1207) begin $display("FAIL mid_frame got %h want 1207", wr_frame); n_fail++; end
    n_checks++;
    if (frame_count !== 8'd1 || err_count !== 8'd0) begin
      $display("FAIL mid_counts got %h/%h want 01/00", frame_count, err_count); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    do_reset();
    #10;
    cap.delete();
    cap_en   = 1'b1;
    mon_last = wr_frame;
    mon_seen = 1'b0;
    mon_gap  = 0;
    stab_viol = 0;
    mon_en   = 1'b1;
    send_frame(16'h1101, r);
    send_frame(16'h1202, r);
    send_frame(16'h0000, r);
    send_frame(16'h0000, r);
    #40;
    mon_en = 1'b0;
    cap_en = 1'b0;
    if (cap.size() != 2) begin $display("FAIL b2b_count got %0d want 2", cap.size()); n_fail++; end
    n_checks++;
    if (cap.size() >= 1) begin
      if (cap[0] !== 16'h1101) begin $display("FAIL b2b_first got %h want 1101", cap[0]); n_fail++; end
    end else begin
      $display("FAIL b2b_first got none want 1101"); n_fail++;
    end
    n_checks++;
    if (cap.size() >= 2) begin
      if (cap[1] !== 16'h1202) begin $display("FAIL b2b_second got %h want 1202", cap[1]); n_fail++; end
    end else begin
      $display("FAIL b2b_second got none want 1202"); n_fail++;
    end
    n_checks++;
    if (stab_viol != 0) begin $display("FAIL b2b_stable got %0d violations want 0", stab_viol); n_fail++; end
    n_checks++;
    if (wr_toggle !== 1'b0) begin $display("FAIL b2b_toggle got %b want 0", wr_toggle); n_fail++; end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reject();
    test_wrap();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
